// File: rtl/mmio_regbank.sv
// mmio_regbank: memory-mapped bank of WORDS 32-bit registers on the peripheral bus.
// It provides byte-enable bus writes and registered reads with a valid pulse.
// Read-only words, a per-word hardware update port and per-word write strobes are included.
// Optional feature macro MMIO_REGBANK_W1C_EN adds the W1C_MASK parameter.
// Words selected by W1C_MASK clear the bits written as 1 instead of loading wd.
module mmio_regbank #(
  parameter int unsigned           WORDS     = 4,
  parameter logic [31:0]           BASE_ADDR = 32'h0000_0000,
  parameter logic [32*WORDS-1:0]   RESET_VAL = '0,
  parameter logic [WORDS-1:0]      RO_MASK   = '0
`ifdef MMIO_REGBANK_W1C_EN
  ,
  parameter logic [WORDS-1:0]      W1C_MASK  = '0
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [31:2]           addr,
  input  logic [31:0]           wd,
  output logic [31:0]           rd,
  output logic                  rvalid,
  output logic                  err,
  output logic [32*WORDS-1:0]   regs_q,
  input  logic [WORDS-1:0]      hw_we,
  input  logic [32*WORDS-1:0]   hw_wd,
  output logic [WORDS-1:0]      wr_pulse
);

  // Word offset from the base. An address below the base wraps to a large value and misses.
  logic [29:0] idx;
  logic        hit;

  assign idx = addr - BASE_ADDR[31:2];
  assign hit = (idx < 30'(WORDS));

  // Expand each byte enable to a mask over its eight data bits.
  logic [31:0] byte_mask;
  assign byte_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  logic [32*WORDS-1:0] regs_d;
  logic [WORDS-1:0]    wr_pulse_d, wr_pulse_q;
  logic [31:0]         rd_word, rd_d, rd_q;
  logic                ro_sel;
  logic                rvalid_d, rvalid_q;
  logic                err_d, err_q;

  // Next-state computation. The hardware update is applied first.
  // The bus then overlays the bytes it enables, so bus bytes win and hw_wd fills the rest.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    regs_d     = regs_q;
    wr_pulse_d = '0;
    rd_word    = '0;
    ro_sel     = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      if (hw_we[i]) begin
        regs_d[32*i +: 32] = hw_wd[32*i +: 32];
      end
      if (hit && (idx == 30'(i))) begin
        // Read data comes from the current register value, so re and we to one word read the old value.
        rd_word = regs_q[32*i +: 32];
        ro_sel  = RO_MASK[i];
        if (we && !RO_MASK[i]) begin
`ifdef MMIO_REGBANK_W1C_EN
          if (W1C_MASK[i]) begin
            regs_d[32*i +: 32] = regs_d[32*i +: 32] & ~(wd & byte_mask);
          end else
`endif
          begin
            regs_d[32*i +: 32] = (wd & byte_mask) | (regs_d[32*i +: 32] & ~byte_mask);
          end
          wr_pulse_d[i] = |be;
        end
      end
    end
    rd_d     = re ? rd_word : rd_q;
    rvalid_d = re;
    err_d    = (re && !hit) || (we && (!hit || ro_sel));
  end

  // Register state and the registered bus-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register in this bank has a defined reset value.
    // A non-zero RESET_VAL here is the power-on contents the peripheral relies on.
    if (!rst_n) begin
      regs_q     <= RESET_VAL;
      rd_q       <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      wr_pulse_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
      regs_q     <= regs_d;
      rd_q       <= rd_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign rd       = rd_q;
  assign rvalid   = rvalid_q;
  assign err      = err_q;
  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_mmio_regbank.sv
// Scoreboard bench for mmio_regbank.
// The driver applies one access per cycle and pushes the model's prediction into queues.
// An independent monitor pops the queues after each clock edge and compares them with the DUT outputs.
module tb_mmio_regbank;

  localparam int          W    = 6;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [29:0] BW   = BASE[31:2];
  // Words 5..0: word0 AAAA_AAAA, word1 DEAD_BEEF, word2 5, word4 0BAD_F00D (read-only).
  localparam logic [32*W-1:0] RV = {32'h0, 32'h0BAD_F00D, 32'h0, 32'h5, 32'hDEAD_BEEF, 32'hAAAA_AAAA};
  localparam logic [W-1:0]    RO = 6'b010000;
`ifdef MMIO_REGBANK_W1C_EN
  localparam logic [W-1:0]    W1C = 6'b000010;
`else
  localparam logic [W-1:0]    W1C = 6'b000000;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            re, we;
  logic [3:0]      be;
  logic [29:0]     addr;
  logic [31:0]     wd;
  logic [31:0]     rd;
  logic            rvalid, err;
  logic [32*W-1:0] regs_q;
  logic [W-1:0]    hw_we;
  logic [32*W-1:0] hw_wd;
  logic [W-1:0]    wr_pulse;

  mmio_regbank #(
    .WORDS(W), .BASE_ADDR(BASE), .RESET_VAL(RV), .RO_MASK(RO)
`ifdef MMIO_REGBANK_W1C_EN
    , .W1C_MASK(W1C)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .be(be), .addr(addr), .wd(wd),
    .rd(rd), .rvalid(rvalid), .err(err), .regs_q(regs_q),
    .hw_we(hw_we), .hw_wd(hw_wd), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rvalid;
    logic [31:0]     rd;
    logic            err;
    logic [W-1:0]    wp;
    logic [32*W-1:0] regs;
  } cyc_t;

  cyc_t        cyc_q[$];
  logic [31:0] rdq[$];
  logic [31:0] m [W];
  logic [31:0] m_rd;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32*W-1:0] hw_word(input int i, input logic [31:0] v);
    logic [32*W-1:0] r;
    r = '0;
    r[32*i +: 32] = v;
    return r;
  endfunction

  function automatic logic [32*W-1:0] pack_model();
    logic [32*W-1:0] r;
    for (int i = 0; i < W; i++) r[32*i +: 32] = m[i];
    return r;
  endfunction

  task automatic set_idle();
    re = 0; we = 0; be = 0; addr = 0; wd = 0; hw_we = 0; hw_wd = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) m[i] = RV[32*i +: 32];
    m_rd = 0;
  endtask

  // One bus cycle. The model predicts the outcome of the next rising edge.
  task automatic drive(input logic r, input logic w, input logic [3:0] b, input logic [29:0] a,
                       input logic [31:0] d, input logic [W-1:0] hwe, input logic [32*W-1:0] hwd);
    cyc_t        e;
    logic [31:0] nxt [W];
    logic [29:0] off;
    bit          hit;
    int          k;
    @(negedge clk);
    re = r; we = w; be = b; addr = a; wd = d; hw_we = hwe; hw_wd = hwd;
    off = a - BW;
    hit = (off < 30'(W));
    k   = hit ? int'(off) : 0;
    e.wp  = '0;
    e.err = (r && !hit) || (w && (!hit || RO[k]));
    if (r) begin
      m_rd = hit ? m[k] : 32'h0;
      rdq.push_back(m_rd);
    end
    for (int i = 0; i < W; i++) nxt[i] = hwe[i] ? hwd[32*i +: 32] : m[i];
    if (w && hit && !RO[k]) begin
      for (int j = 0; j < 4; j++) begin
        if (b[j]) begin
          if (W1C[k]) nxt[k][8*j +: 8] = nxt[k][8*j +: 8] & ~d[8*j +: 8];
          else        nxt[k][8*j +: 8] = d[8*j +: 8];
        end
      end
      e.wp[k] = (b != 4'b0000);
    end
    for (int i = 0; i < W; i++) m[i] = nxt[i];
    e.rvalid = r;
    e.rd     = m_rd;
    e.regs   = pack_model();
    cyc_q.push_back(e);
    @(posedge clk);
    #1;
    set_idle();
  endtask

  // Monitor: compares every predicted cycle and pops read data whenever rvalid is seen.
  initial begin
    cyc_t e;
    forever begin
      @(posedge clk);
      #2;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("sb_rvalid", 256'(rvalid), 256'(e.rvalid));
        check("sb_rd_hold", 256'(rd), 256'(e.rd));
        check("sb_err", 256'(err), 256'(e.err));
        check("sb_wr_pulse", 256'(wr_pulse), 256'(e.wp));
        check("sb_regs", 256'(regs_q), 256'(e.regs));
      end
      if (rvalid === 1'b1) begin
        if (rdq.size() > 0) begin
          check("sb_read_data", 256'(rd), 256'(rdq.pop_front()));
        end else begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_rvalid: got rvalid=1 expected no read pending");
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]    rhwe;
    logic [32*W-1:0] rhwd;
    logic [29:0]     raddr;
    rst_n = 0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_regs", 256'(regs_q), 256'(RV));
    check("reset_rd", 256'(rd), 256'(0));
    check("reset_rvalid", 256'(rvalid), 256'(0));
    check("reset_err", 256'(err), 256'(0));
    check("reset_wr_pulse", 256'(wr_pulse), 256'(0));
    rst_n = 1;

    drive(1, 0, 4'h0, BW + 1, 0, 0, 0);
    check("read_reset_word1", 256'(rd), 256'(32'hDEAD_BEEF));
    check("read_reset_rvalid", 256'(rvalid), 256'(1));
    check("read_reset_err", 256'(err), 256'(0));

    drive(0, 1, 4'b0101, BW, 32'h1122_3344, 0, 0);
    check("be_write_word0", 256'(regs_q[31:0]), 256'(32'hAA22_AA44));
    check("be_write_pulse", 256'(wr_pulse), 256'(6'b000001));
    drive(0, 0, 4'h0, 0, 0, 0, 0);
    check("pulse_one_cycle", 256'(wr_pulse), 256'(0));
    check("rvalid_one_cycle", 256'(rvalid), 256'(0));

    drive(1, 1, 4'hF, BW + 2, 32'h9, 0, 0);
    check("rbw_old_value", 256'(rd), 256'(32'h5));
    drive(1, 0, 4'h0, BW + 2, 0, 0, 0);
    check("rbw_new_value", 256'(rd), 256'(32'h9));

    drive(0, 1, 4'hF, BW + 4, 32'h1234_5678, 0, 0);
    check("ro_write_err", 256'(err), 256'(1));
    check("ro_write_unchanged", 256'(regs_q[32*4 +: 32]), 256'(32'h0BAD_F00D));
    drive(1, 0, 4'h0, BW + W, 0, 0, 0);
    check("miss_read_rd", 256'(rd), 256'(0));
    check("miss_read_rvalid", 256'(rvalid), 256'(1));
    check("miss_read_err", 256'(err), 256'(1));
    drive(0, 0, 4'h0, 0, 0, 0, 0);
    check("err_one_cycle", 256'(err), 256'(0));
    drive(1, 0, 4'h0, BW - 1, 0, 0, 0);
    check("below_base_err", 256'(err), 256'(1));

    drive(0, 1, 4'b0011, BW + 3, 32'h0, 6'b001000, hw_word(3, 32'hFFFF_FFFF));
    check("hw_bus_merge", 256'(regs_q[32*3 +: 32]), 256'(32'hFFFF_0000));
    drive(0, 1, 4'hF, BW + 4, 32'h0, 6'b010000, hw_word(4, 32'hCAFE_0001));
    check("hw_on_ro_word", 256'(regs_q[32*4 +: 32]), 256'(32'hCAFE_0001));
    check("hw_on_ro_err", 256'(err), 256'(1));
    drive(0, 1, 4'b0000, BW + 5, 32'hFFFF_FFFF, 0, 0);
    check("be_zero_pulse", 256'(wr_pulse), 256'(0));
    check("be_zero_err", 256'(err), 256'(0));
    check("be_zero_word5", 256'(regs_q[32*5 +: 32]), 256'(0));
`ifdef MMIO_REGBANK_W1C_EN
    drive(0, 0, 4'h0, 0, 0, 6'b000010, hw_word(1, 32'h0000_00F0));
    drive(0, 1, 4'hF, BW + 1, 32'h30, 0, 0);
    check("w1c_clear", 256'(regs_q[32*1 +: 32]), 256'(32'h0000_00C0));
`endif

    for (int n = 0; n < 400; n++) begin
      rhwe = W'($urandom) & W'($urandom) & W'($urandom);
      for (int i = 0; i < W; i++) rhwd[32*i +: 32] = $urandom;
      if ($urandom_range(0, 15) == 0) raddr = 30'($urandom);
      else raddr = BW + 30'($urandom_range(0, W + 2)) - 30'd1;
      drive(1'($urandom), 1'($urandom), 4'($urandom), raddr, $urandom, rhwe, rhwd);
    end

    // Reset in the middle of an access: the access is dropped and nothing pulses afterwards.
    @(negedge clk);
    re = 1; we = 1; be = 4'hF; addr = BW; wd = 32'h5555_5555;
    #2;
    rst_n = 0;
    #1;
    check("midreset_regs", 256'(regs_q), 256'(RV));
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    check("postreset_rvalid", 256'(rvalid), 256'(0));
    check("postreset_err", 256'(err), 256'(0));
    check("postreset_wr_pulse", 256'(wr_pulse), 256'(0));
    check("postreset_rd", 256'(rd), 256'(0));
    check("postreset_regs", 256'(regs_q), 256'(RV));
    drive(1, 0, 4'h0, BW, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    check("queues_drained", 256'(cyc_q.size() + rdq.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
